mems_dac_spi_master: RTL and testbench

- Serial transmitter between the MEMS mirror sequencer and the quad MEMS driver DAC.
- Accepts one 24-bit DAC command word per start pulse (command/address/data, MSB first) and drives the frame on SCLK/MOSI/SYNC_n.
- Reports busy and done back to the sequencer.
- Sequencer issues a new start only when busy is low and its own previous start has retired.

---
 rtl/mems_dac_spi_master.sv | 150 +++++++++++++++
 tb/tb_mems_dac_spi_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mems_dac_spi_master.sv
// SPI master framing one DATA_WIDTH-bit DAC command per start (MSB first, sampled on falling sclk).
// Optional frame counter output under `define MEMS_DAC_SPI_FRAME_CNT_EN.
module mems_dac_spi_master #(
  parameter int CLK_DIV    = 2,
  parameter int DATA_WIDTH = 24,
  parameter int SYNC_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  sync_n
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_count
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_RLD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RLD = 8'(SYNC_GAP - 1);
  localparam logic [4:0] BIT_TOP = 5'(DATA_WIDTH - 1);

  state_t                state, state_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic [4:0]            bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  busy_nxt, done_nxt, sclk_nxt, mosi_nxt, sync_n_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b1;
      mosi    <= 1'b0;
      sync_n  <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_nxt;
      shreg   <= shreg_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      sclk    <= sclk_nxt;
      mosi    <= mosi_nxt;
      sync_n  <= sync_n_nxt;
    end
  end

  // Every output is computed one cycle ahead and registered, so start/data_in never reach a pin combinationally.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    sclk_nxt   = sclk;
    mosi_nxt   = mosi;
    sync_n_nxt = sync_n;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SETUP;
          cnt_nxt    = DIV_RLD;
          bit_nxt    = BIT_TOP;
          shreg_nxt  = data_in;
          busy_nxt   = 1'b1;
          sync_n_nxt = 1'b0;
          sclk_nxt   = 1'b1;
          mosi_nxt   = data_in[DATA_WIDTH-1];
        end
      end
      SETUP: begin
        if (cnt == 8'd0) begin
          state_nxt = SHIFT;
          cnt_nxt   = DIV_RLD;
          sclk_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      SHIFT: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          cnt_nxt = DIV_RLD;
          if (!sclk) begin
            // Rising edge: present the next bit so it settles a full high half before the DAC samples it.
            sclk_nxt = 1'b1;
            if (bit_cnt != 5'd0) begin
              shreg_nxt = {shreg[DATA_WIDTH-2:0], shreg[DATA_WIDTH-1]};
              mosi_nxt  = shreg[DATA_WIDTH-2];
            end
          end else if (bit_cnt == 5'd0) begin
            state_nxt = HOLD;
          end else begin
            bit_nxt  = bit_cnt - 5'd1;
            sclk_nxt = 1'b0;
          end
        end
      end
      HOLD: begin
        if (cnt == 8'd0) begin
          state_nxt  = GAP;
          cnt_nxt    = GAP_RLD;
          sync_n_nxt = 1'b1;
          mosi_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      GAP: begin
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        busy_nxt   = 1'b0;
        sclk_nxt   = 1'b1;
        mosi_nxt   = 1'b0;
        sync_n_nxt = 1'b1;
      end
    endcase
  end

`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
  // Counts only frames that reach done; a reset abort never produces done_nxt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_count <= '0;
    else if (done_nxt) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mems_dac_spi_master.sv
// Bench for mems_dac_spi_master: three divider configurations, vector table plus randomized frames.
module tb_mems_dac_spi_master;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    start_a = '0;
  logic [DW-1:0] data_in = '0;
  logic [2:0]    busy_a, done_a, sclk_a, mosi_a, sync_a;
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
  logic [15:0]   frame_count, fc1, fc2;
  logic [15:0]   fc_model = '0;
`endif

  int checks = 0;
  int errors = 0;

  // Per-instance configuration as seen by the reference model.
  int cd_of[3]  = '{2, 1, 5};
  int gap_of[3] = '{4, 1, 14};

  always #5 clk = ~clk;

  mems_dac_spi_master #(.CLK_DIV(2), .DATA_WIDTH(DW), .SYNC_GAP(4)) u0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .data_in(data_in),
    .busy(busy_a[0]), .done(done_a[0]), .sclk(sclk_a[0]), .mosi(mosi_a[0]), .sync_n(sync_a[0])
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
    , .frame_count(frame_count)
`endif
  );
  mems_dac_spi_master #(.CLK_DIV(1), .DATA_WIDTH(DW), .SYNC_GAP(1)) u1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .data_in(data_in),
    .busy(busy_a[1]), .done(done_a[1]), .sclk(sclk_a[1]), .mosi(mosi_a[1]), .sync_n(sync_a[1])
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
    , .frame_count(fc1)
`endif
  );
  mems_dac_spi_master #(.CLK_DIV(5), .DATA_WIDTH(DW), .SYNC_GAP(14)) u2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .data_in(data_in),
    .busy(busy_a[2]), .done(done_a[2]), .sclk(sclk_a[2]), .mosi(mosi_a[2]), .sync_n(sync_a[2])
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
    , .frame_count(fc2)
`endif
  );

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int n_of(input int s);
    return cd_of[s] * (2 * DW + 2) + gap_of[s];
  endfunction

  task automatic chk_idle(input string tag);
    for (int s = 0; s < 3; s++) begin
      check({tag, " sclk"},   sclk_a[s], 1);
      check({tag, " sync_n"}, sync_a[s], 1);
      check({tag, " mosi"},   mosi_a[s], 0);
      check({tag, " busy"},   busy_a[s], 0);
      check({tag, " done"},   done_a[s], 0);
    end
  endtask

  task automatic issue(input int s, input logic [DW-1:0] w);
    @(negedge clk);
    start_a[s] = 1'b1;
    data_in    = w;
  endtask

  // Start has already been presented in cycle 0; watch cycles 1..n+1 and compare against the frame rules.
  task automatic observe(input int s, input logic [DW-1:0] w, input int n, input bit blocked,
                         input bit chain, input logic [DW-1:0] nxt);
    int busy_first = 0, busy_last = 0, busy_cnt = 0, sync_first = 0, sync_last = 0;
    int done_cnt = 0, done_cyc = 0, falls = 0, last_fall = 0, space_err = 0, stab_err = 0;
    int gap_err = 0, zero_mosi = 0, mosi1 = 0;
    logic [DW-1:0] bits = '0;
    logic prev_sclk = 1'b1, prev_mosi = 1'b0;
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start_a = '0;
        data_in = DW'($urandom);
        mosi1   = int'(mosi_a[s]);
      end
      if (blocked && (c == 10 || c == 50)) begin
        start_a[s] = 1'b1;
        data_in    = DW'($urandom);
      end
      if (blocked && (c == 11 || c == 51)) start_a[s] = 1'b0;
      if (busy_a[s]) begin
        if (busy_first == 0) busy_first = c;
        busy_last = c;
        busy_cnt++;
      end
      if (!sync_a[s]) begin
        if (sync_first == 0) sync_first = c;
        sync_last = c;
        if (!mosi_a[s]) zero_mosi++;
      end else if (busy_a[s] && mosi_a[s]) begin
        gap_err++;
      end
      if (done_a[s]) begin
        done_cnt++;
        done_cyc = c;
      end
      if (prev_sclk && !sclk_a[s]) begin
        falls++;
        bits = {bits[DW-2:0], mosi_a[s]};
        if (mosi_a[s] != prev_mosi) stab_err++;
        if (last_fall != 0 && c - last_fall != 2 * cd_of[s]) space_err++;
        last_fall = c;
      end
      prev_sclk = sclk_a[s];
      prev_mosi = mosi_a[s];
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
      if (s == 0 && c == n + 1) begin
        fc_model = fc_model + 16'd1;
        check("frame_count", frame_count, fc_model);
      end
`endif
      if (chain && c == n + 1) begin
        start_a[s] = 1'b1;
        data_in    = nxt;
      end
    end
    check("busy_first", busy_first, 1);
    check("busy_last", busy_last, n);
    check("busy_cycles", busy_cnt, n);
    check("sync_first", sync_first, 1);
    check("sync_last", sync_last, n - gap_of[s]);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, n + 1);
    check("fall_edges", falls, DW);
    check("frame_bits", bits, w);
    check("mosi_cycle1", mosi1, int'(w[DW-1]));
    check("fall_spacing_err", space_err, 0);
    check("mosi_stable_err", stab_err, 0);
    check("gap_mosi_err", gap_err, 0);
    if (w == '1) check("mosi_zero_in_frame", zero_mosi, 0);
  endtask

  typedef struct {
    int            sel;
    logic [DW-1:0] word;
    bit            preissued;
    bit            blocked;
    bit            chain;
    logic [DW-1:0] nxt;
    int            exp_n;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{0, 24'h3FA5C3, 1'b0, 1'b0, 1'b1, 24'h280001, 104};
    vecs[1] = '{0, 24'h280001, 1'b1, 1'b0, 1'b0, 24'h0,      104};
    vecs[2] = '{0, 24'h123456, 1'b0, 1'b1, 1'b0, 24'h0,      104};
    vecs[3] = '{1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 24'h0,      51};
    vecs[4] = '{2, 24'hA5C35A, 1'b0, 1'b0, 1'b0, 24'h0,      264};

    repeat (3) begin
      @(negedge clk);
      chk_idle("por");
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      if (!vecs[i].preissued) issue(vecs[i].sel, vecs[i].word);
      observe(vecs[i].sel, vecs[i].word, vecs[i].exp_n, vecs[i].blocked, vecs[i].chain, vecs[i].nxt);
      if (vecs[i].blocked) begin
        int extra = 0;
        repeat (30) begin
          @(negedge clk);
          if (busy_a[vecs[i].sel]) extra++;
        end
        check("blocked_extra_busy", extra, 0);
      end
    end

    // Reset asserted between clock edges and held 5 cycles.
    @(posedge clk);
    #3 rst = 1'b0;
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
    fc_model = '0;
`endif
    #1 chk_idle("rst_async");
    repeat (5) begin
      @(negedge clk);
      chk_idle("rst_neg");
      @(posedge clk);
      #1 chk_idle("rst_pos");
    end
    @(negedge clk);
    rst = 1'b1;

    // Abort a frame at cycle 30, then confirm the next frame is intact.
    issue(0, 24'h5A0F33);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start_a = '0;
    end
    check("pre_abort_sync_low", sync_a[0], 0);
    #2 rst = 1'b0;
    #1 check("abort_sync_n", sync_a[0], 1);
    check("abort_busy", busy_a[0], 0);
    check("abort_sclk", sclk_a[0], 1);
    begin
      int dn = 0;
      repeat (4) begin
        @(negedge clk);
        if (done_a[0]) dn++;
      end
      rst = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (done_a[0]) dn++;
      end
      check("abort_done_pulses", dn, 0);
    end
`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
    fc_model = '0;
    check("abort_not_counted", frame_count, 0);
`endif
    issue(0, 24'hC0FFEE);
    observe(0, 24'hC0FFEE, 104, 1'b0, 1'b0, '0);

`ifdef MEMS_DAC_SPI_FRAME_CNT_EN
    @(negedge clk);
    force u0.frame_count = 16'hFFFF;
    @(negedge clk);
    release u0.frame_count;
    fc_model = 16'hFFFF;
    issue(0, 24'h0F0F0F);
    observe(0, 24'h0F0F0F, 104, 1'b0, 1'b0, '0);
    check("frame_count_wrap", frame_count, 0);
`endif

    for (int k = 0; k < 6; k++) begin
      int s;
      logic [DW-1:0] w;
      s = int'($urandom_range(0, 2));
      w = DW'($urandom);
      issue(s, w);
      observe(s, w, n_of(s), 1'b0, 1'b0, '0);
      repeat (int'($urandom_range(1, 4))) @(negedge clk);
    end

    @(negedge clk);
    chk_idle("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
